// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/eret sequencer: FSM states, CP0
// register numbers and the default handler entry address.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_EXC   = 2'd1,
        ST_RET   = 2'd2,
        ST_GUARD = 2'd3
    } exc_state_e;

    localparam logic [4:0]  EXC_INT       = 5'd0;
    localparam logic [4:0]  CP0_SR        = 5'd12;
    localparam logic [4:0]  CP0_CAUSE     = 5'd13;
    localparam logic [4:0]  CP0_EPC       = 5'd14;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

    // True when an mtc0 in W is overwriting EPC this very cycle.
    function automatic logic is_epc_write(input logic we, input logic [4:0] addr);
        return we && (addr == CP0_EPC);
    endfunction

endpackage

// File: rtl/exc_guard_cnt.sv
// Post-eret guard counter: load, decrement, and a flag that tells the FSM
// the current decrement brings the count to zero.
module exc_guard_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_next
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero_next = (r_count <= W'(1));

endmodule

// File: rtl/exc_ctrl.sv
// Exception entry / eret return sequencer sitting between the M stage and
// CP0: gates interrupts, drives CP0 exception inputs, kills and redirects.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [3:0]  GUARD_CYC = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_in,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exccode,
    input  logic        m_eret,
    input  logic        w_cp0_we,
    input  logic [4:0]  w_cp0_addr,
    input  logic [31:0] w_cp0_wdat,
    input  logic        cp0_exctr,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  dev_int,
    output logic        pr_er,
    output logic [4:0]  er_code,
    output logic [31:0] vpc,
    output logic        is_bd,
    output logic        exlclr,
    output logic        kill_m,
    output logic        flush,
    output logic        redirect_en,
    output logic [31:0] redirect_pc
);

    exc_state_e  r_state;
    exc_state_e  w_state_next;
    logic [31:0] r_ret_pc;
    logic [31:0] w_ret_pc_next;
    logic        w_cnt_clr;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero_next;

    exc_guard_cnt #(.W(4)) u_guard_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_cnt_clr),
        .i_load      (w_cnt_load),
        .i_load_val  (GUARD_CYC),
        .i_dec       (w_cnt_dec),
        .o_zero_next (w_cnt_zero_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_ret_pc <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ret_pc <= w_ret_pc_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ret_pc_next = r_ret_pc;
        w_cnt_clr     = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        dev_int       = '0;
        pr_er         = 1'b0;
        er_code       = '0;
        vpc           = '0;
        is_bd         = 1'b0;
        exlclr        = 1'b0;
        kill_m        = 1'b0;
        flush         = 1'b0;
        redirect_en   = 1'b0;
        redirect_pc   = '0;

        case (r_state)
            ST_RUN, ST_GUARD: begin
                pr_er   = m_valid && (m_exccode != EXC_INT);
                er_code = m_exccode;
                vpc     = m_pc;
                is_bd   = m_bd;
                // Interrupts are only offered against a real instruction outside the guard.
                dev_int = int_in & {6{m_valid && (r_state == ST_RUN)}};
                if (cp0_exctr) begin
                    kill_m       = 1'b1;
                    w_state_next = ST_EXC;
                    w_cnt_clr    = 1'b1;
                end else if (m_valid && m_eret) begin
                    exlclr        = 1'b1;
                    w_ret_pc_next = is_epc_write(w_cp0_we, w_cp0_addr) ? w_cp0_wdat : cp0_epc;
                    w_state_next  = ST_RET;
                    w_cnt_clr     = 1'b1;
                end else if (r_state == ST_GUARD) begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_zero_next) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_EXC: begin
                kill_m       = 1'b1;
                flush        = 1'b1;
                redirect_en  = 1'b1;
                redirect_pc  = EXC_ENTRY;
                w_state_next = ST_RUN;
            end
            ST_RET: begin
                kill_m      = 1'b1;
                flush       = 1'b1;
                redirect_en = 1'b1;
                redirect_pc = r_ret_pc;
                if (GUARD_CYC == 4'd0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_GUARD;
                    w_cnt_load   = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase

        // Nothing leaves the block while reset is asserted.
        if (rst) begin
            dev_int     = '0;
            pr_er       = 1'b0;
            er_code     = '0;
            vpc         = '0;
            is_bd       = 1'b0;
            exlclr      = 1'b0;
            kill_m      = 1'b0;
            flush       = 1'b0;
            redirect_en = 1'b0;
            redirect_pc = '0;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized
// run against a cycle-timeline reference model.
module tb_exc_ctrl;

    localparam logic [31:0] ENTRY = 32'h0000_4180;
    localparam int          GCYC  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_in;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exccode;
    logic        m_eret;
    logic        w_cp0_we;
    logic [4:0]  w_cp0_addr;
    logic [31:0] w_cp0_wdat;
    logic        cp0_exctr;
    logic [31:0] cp0_epc;
    logic [5:0]  dev_int;
    logic        pr_er;
    logic [4:0]  er_code;
    logic [31:0] vpc;
    logic        is_bd;
    logic        exlclr;
    logic        kill_m;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .int_in      (int_in),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_bd        (m_bd),
        .m_exccode   (m_exccode),
        .m_eret      (m_eret),
        .w_cp0_we    (w_cp0_we),
        .w_cp0_addr  (w_cp0_addr),
        .w_cp0_wdat  (w_cp0_wdat),
        .cp0_exctr   (cp0_exctr),
        .cp0_epc     (cp0_epc),
        .dev_int     (dev_int),
        .pr_er       (pr_er),
        .er_code     (er_code),
        .vpc         (vpc),
        .is_bd       (is_bd),
        .exlclr      (exlclr),
        .kill_m      (kill_m),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
    );

    // Reference model: a timeline of absolute cycle numbers. A taken event at
    // cycle t schedules a redirect at t+1 and masks interrupts through mask_end.
    int          cyc;
    int          redir_cyc;
    logic [31:0] redir_pc_m;
    int          mask_end;
    int          nx_redir_cyc;
    logic [31:0] nx_redir_pc;
    int          nx_mask_end;
    logic [5:0]  e_dev_int;
    logic        e_pr_er, e_is_bd, e_exlclr, e_kill_m, e_flush, e_redirect_en, e_intake;
    logic [4:0]  e_er_code;
    logic [31:0] e_vpc, e_redirect_pc;

    task automatic model_eval();
        e_dev_int = '0; e_pr_er = 0; e_er_code = '0; e_vpc = '0; e_is_bd = 0;
        e_exlclr = 0; e_kill_m = 0; e_flush = 0; e_redirect_en = 0; e_redirect_pc = '0;
        e_intake = 0;
        nx_redir_cyc = redir_cyc; nx_redir_pc = redir_pc_m; nx_mask_end = mask_end;
        if (rst) begin
            e_intake = 1;
        end else if (cyc == redir_cyc) begin
            e_kill_m = 1; e_flush = 1; e_redirect_en = 1; e_redirect_pc = redir_pc_m;
        end else begin
            e_intake  = 1;
            e_pr_er   = m_valid && (m_exccode != 0);
            e_er_code = m_exccode;
            e_vpc     = m_pc;
            e_is_bd   = m_bd;
            e_dev_int = (m_valid && cyc > mask_end) ? int_in : 6'd0;
            if (cp0_exctr) begin
                e_kill_m = 1;
                nx_redir_cyc = cyc + 1; nx_redir_pc = ENTRY; nx_mask_end = cyc + 1;
            end else if (m_valid && m_eret) begin
                e_exlclr = 1;
                nx_redir_cyc = cyc + 1;
                nx_redir_pc  = (w_cp0_we && w_cp0_addr == 5'd14) ? w_cp0_wdat : cp0_epc;
                nx_mask_end  = cyc + 1 + GCYC;
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            redir_cyc = -1; mask_end = -1;
        end else begin
            redir_cyc = nx_redir_cyc; redir_pc_m = nx_redir_pc; mask_end = nx_mask_end;
        end
        cyc++;
    endtask

    task automatic idle();
        int_in = '0; m_valid = 0; m_pc = '0; m_bd = 0; m_exccode = '0; m_eret = 0;
        w_cp0_we = 0; w_cp0_addr = '0; w_cp0_wdat = '0; cp0_exctr = 0; cp0_epc = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            int_in = 6'($urandom); m_valid = 1; m_pc = $urandom; m_exccode = 5'd12;
            m_eret = 1; cp0_exctr = 1; m_bd = 1;
            @(negedge clk);
            checks++;
            if ({dev_int, pr_er, er_code, vpc, is_bd, exlclr, kill_m, flush, redirect_en, redirect_pc} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got dev_int=%h pr_er=%b kill_m=%b flush=%b redirect_en=%b want all 0",
                         dev_int, pr_er, kill_m, flush, redirect_en);
            end
            next_cyc();
        end
        rst = 0; idle();
        @(negedge clk);
        checks++;
        if ({dev_int, pr_er, exlclr, kill_m, flush, redirect_en, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL reset_release: got kill_m=%b flush=%b redirect_en=%b want 0", kill_m, flush, redirect_en);
        end
        next_cyc();
    endtask

    task automatic test_overflow();
        idle(); m_valid = 1; m_pc = 32'h3010; m_exccode = 5'd12; cp0_exctr = 1;
        @(negedge clk);
        checks++;
        if ({pr_er, kill_m, flush, redirect_en} !== 4'b1100 || vpc !== 32'h3010 || er_code !== 5'd12) begin
            errors++;
            $display("FAIL ovf_t: got pr_er=%b kill=%b flush=%b ren=%b vpc=%h code=%0d want 1 1 0 0 3010 12",
                     pr_er, kill_m, flush, redirect_en, vpc, er_code);
        end
        next_cyc(); idle(); m_valid = 1; m_exccode = 5'd12;
        @(negedge clk);
        checks++;
        if ({kill_m, flush, redirect_en, pr_er} !== 4'b1110 || redirect_pc !== ENTRY) begin
            errors++;
            $display("FAIL ovf_t1: got kill=%b flush=%b ren=%b pr_er=%b rpc=%h want 1 1 1 0 %h",
                     kill_m, flush, redirect_en, pr_er, redirect_pc, ENTRY);
        end
        next_cyc(); idle(); m_valid = 1; int_in = 6'h01;
        @(negedge clk);
        checks++;
        if (redirect_en !== 1'b0 || redirect_pc !== 32'h0 || dev_int !== 6'h01) begin
            errors++;
            $display("FAIL ovf_t2: got ren=%b rpc=%h dev_int=%h want 0 0 01", redirect_en, redirect_pc, dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_bubble_int();
        idle(); int_in = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dev_int !== 6'd0) begin
                errors++;
                $display("FAIL bubble_%0d: got dev_int=%b want 000000", i, dev_int);
            end
            next_cyc();
        end
        m_valid = 1; m_pc = 32'h3020;
        @(negedge clk);
        checks++;
        if (dev_int !== 6'b000100) begin
            errors++;
            $display("FAIL bubble_valid: got dev_int=%b want 000100", dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_eret_fwd();
        idle(); m_valid = 1; m_eret = 1; w_cp0_we = 1; w_cp0_addr = 5'd14;
        w_cp0_wdat = 32'h3044; cp0_epc = 32'h3000;
        @(negedge clk);
        checks++;
        if (exlclr !== 1'b1 || redirect_en !== 1'b0 || kill_m !== 1'b0) begin
            errors++;
            $display("FAIL eret_t: got exlclr=%b ren=%b kill=%b want 1 0 0", exlclr, redirect_en, kill_m);
        end
        next_cyc(); idle(); cp0_epc = 32'h3000;
        @(negedge clk);
        checks++;
        if (redirect_en !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h3044) begin
            errors++;
            $display("FAIL eret_fwd_pc: got ren=%b flush=%b rpc=%h want 1 1 00003044", redirect_en, flush, redirect_pc);
        end
        for (int i = 0; i < GCYC + 1; i++) next_cyc();
        idle();
    endtask

    task automatic test_guard();
        idle(); m_valid = 1; m_eret = 1; cp0_epc = 32'h3000; int_in = 6'h01;
        @(negedge clk);
        checks++;
        if (exlclr !== 1'b1) begin
            errors++;
            $display("FAIL guard_exlclr: got %b want 1", exlclr);
        end
        next_cyc(); m_eret = 0;
        @(negedge clk);
        checks++;
        if (redirect_pc !== 32'h3000 || dev_int !== 6'd0) begin
            errors++;
            $display("FAIL guard_ret: got rpc=%h dev_int=%h want 00003000 00", redirect_pc, dev_int);
        end
        next_cyc();
        for (int i = 0; i < GCYC; i++) begin
            @(negedge clk);
            checks++;
            if (dev_int !== 6'd0 || redirect_en !== 1'b0) begin
                errors++;
                $display("FAIL guard_mask_%0d: got dev_int=%h ren=%b want 00 0", i, dev_int, redirect_en);
            end
            next_cyc();
        end
        @(negedge clk);
        checks++;
        if (dev_int !== 6'h01) begin
            errors++;
            $display("FAIL guard_open: got dev_int=%h want 01", dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_exc_beats_eret();
        idle(); m_valid = 1; m_eret = 1; cp0_exctr = 1; cp0_epc = 32'h5555_0000;
        @(negedge clk);
        checks++;
        if (exlclr !== 1'b0 || kill_m !== 1'b1) begin
            errors++;
            $display("FAIL prio_t: got exlclr=%b kill=%b want 0 1", exlclr, kill_m);
        end
        next_cyc(); idle();
        @(negedge clk);
        checks++;
        if (redirect_en !== 1'b1 || redirect_pc !== ENTRY) begin
            errors++;
            $display("FAIL prio_redirect: got ren=%b rpc=%h want 1 %h", redirect_en, redirect_pc, ENTRY);
        end
        next_cyc(); m_valid = 1; int_in = 6'h20;
        @(negedge clk);
        checks++;
        if (dev_int !== 6'h20) begin
            errors++;
            $display("FAIL prio_noguard: got dev_int=%h want 20", dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_reset_mid();
        idle(); m_valid = 1; m_eret = 1; cp0_epc = 32'h3100;
        next_cyc(); idle(); rst = 1;
        @(negedge clk);
        checks++;
        if ({kill_m, flush, redirect_en} !== 3'b000 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_ret: got kill=%b flush=%b ren=%b rpc=%h want 0 0 0 0", kill_m, flush, redirect_en, redirect_pc);
        end
        next_cyc(); rst = 0;
        @(negedge clk);
        checks++;
        if ({dev_int, pr_er, exlclr, kill_m, flush, redirect_en, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL rstmid_after: got kill=%b flush=%b ren=%b rpc=%h want all 0", kill_m, flush, redirect_en, redirect_pc);
        end
        next_cyc(); m_valid = 1; int_in = 6'h02;
        @(negedge clk);
        checks++;
        if (dev_int !== 6'h02) begin
            errors++;
            $display("FAIL rstmid_run: got dev_int=%h want 02", dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_back_to_back();
        idle(); m_valid = 1; m_eret = 1; cp0_epc = 32'h3200; int_in = 6'h01;
        next_cyc(); m_eret = 0;
        next_cyc(); cp0_exctr = 1; m_exccode = 5'd4; m_pc = 32'h3204;
        @(negedge clk);
        checks++;
        if (kill_m !== 1'b1 || dev_int !== 6'd0 || pr_er !== 1'b1 || vpc !== 32'h3204) begin
            errors++;
            $display("FAIL b2b_guard_exc: got kill=%b dev_int=%h pr_er=%b vpc=%h want 1 00 1 00003204",
                     kill_m, dev_int, pr_er, vpc);
        end
        next_cyc(); cp0_exctr = 0; m_exccode = 0;
        @(negedge clk);
        checks++;
        if (redirect_pc !== ENTRY || flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_redirect: got rpc=%h flush=%b want %h 1", redirect_pc, flush, ENTRY);
        end
        next_cyc();
        @(negedge clk);
        checks++;
        if (dev_int !== 6'h01) begin
            errors++;
            $display("FAIL b2b_guard_dropped: got dev_int=%h want 01", dev_int);
        end
        next_cyc(); idle();
    endtask

    task automatic test_random();
        idle(); rst = 1;
        cyc = 0; redir_cyc = -1; mask_end = -1; redir_pc_m = '0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                rst        = ($urandom_range(0, 49) == 0);
                int_in     = 6'($urandom);
                m_valid    = 1'($urandom);
                m_pc       = $urandom;
                m_bd       = 1'($urandom);
                m_exccode  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
                m_eret     = ($urandom_range(0, 5) == 0);
                cp0_exctr  = ($urandom_range(0, 9) == 0);
                w_cp0_we   = 1'($urandom);
                w_cp0_addr = 1'($urandom) ? 5'd14 : 5'($urandom);
                w_cp0_wdat = $urandom;
                cp0_epc    = $urandom;
            end
            @(negedge clk);
            model_eval();
            checks++;
            if ({dev_int, pr_er, exlclr, kill_m, flush, redirect_en} !==
                {e_dev_int, e_pr_er, e_exlclr, e_kill_m, e_flush, e_redirect_en}) begin
                errors++;
                $display("FAIL rnd_ctrl cyc %0d: got dev/pr/exl/kill/flush/ren=%h %b%b%b%b%b want %h %b%b%b%b%b",
                         i, dev_int, pr_er, exlclr, kill_m, flush, redirect_en,
                         e_dev_int, e_pr_er, e_exlclr, e_kill_m, e_flush, e_redirect_en);
            end
            checks++;
            if (redirect_pc !== e_redirect_pc) begin
                errors++;
                $display("FAIL rnd_redirect_pc cyc %0d: got %h want %h", i, redirect_pc, e_redirect_pc);
            end
            if (e_intake && !rst) begin
                checks++;
                if ({er_code, vpc, is_bd} !== {e_er_code, e_vpc, e_is_bd}) begin
                    errors++;
                    $display("FAIL rnd_intake cyc %0d: got code=%0d vpc=%h bd=%b want %0d %h %b",
                             i, er_code, vpc, is_bd, e_er_code, e_vpc, e_is_bd);
                end
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        rst = 0; idle();
        next_cyc();
    endtask

    initial begin
        idle(); rst = 1;
        #1;
        test_reset();
        test_overflow();
        test_bubble_int();
        test_eret_fwd();
        test_guard();
        test_exc_beats_eret();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
